// File: rtl/sha3_padder_dilithium_pkg.sv
// Shared encodings and constants for the Dilithium SHA3/SHAKE padder and F permutation.
// Mode encodings, per-mode rates, domain-separation bytes and the pad end byte.
package sha3_padder_dilithium_pkg;

  localparam int unsigned WORD_W    = 64;
  localparam int unsigned BLK_W     = 1344;
  localparam int unsigned MAX_WORDS = 21;
  localparam int unsigned CNT_W     = 5;

  localparam logic [1:0] MODE_XOF = 2'd0;
  localparam logic [1:0] MODE_KDF = 2'd1;
  localparam logic [1:0] MODE_PRF = 2'd1;
  localparam logic [1:0] MODE_H   = 2'd2;
  localparam logic [1:0] MODE_G   = 2'd3;

  localparam int unsigned RATE_SHAKE128 = 21;
  localparam int unsigned RATE_SHAKE256 = 17;
  localparam int unsigned RATE_SHA3_512 = 9;

  localparam logic [7:0] DOMAIN_SHAKE = 8'h1F;
  localparam logic [7:0] DOMAIN_SHA3  = 8'h06;
  localparam logic [7:0] END_BYTE     = 8'h80;

  // Index of the last rate word for a mode.
  function automatic logic [CNT_W-1:0] last_word_idx(input logic [1:0] m);
    if (m == MODE_XOF)
      return CNT_W'(RATE_SHAKE128 - 1);
    else if (m == MODE_KDF || m == MODE_PRF || m == MODE_H)
      return CNT_W'(RATE_SHAKE256 - 1);
    else
      return CNT_W'(RATE_SHA3_512 - 1);
  endfunction

  function automatic logic [7:0] domain_byte(input logic [1:0] m);
    return (m == MODE_G) ? DOMAIN_SHA3 : DOMAIN_SHAKE;
  endfunction

endpackage

// File: rtl/sha3_padder_dilithium_if.sv
// Message-in / rate-block-out bus between the message source, padder and permutation.
interface sha3_padder_dilithium_if;
  import sha3_padder_dilithium_pkg::*;

  logic [1:0]        mode;
  logic [WORD_W-1:0] data_in;
  logic              in_valid;
  logic              is_last;
  logic [2:0]        byte_num;
  logic              buffer_full;
  logic [BLK_W-1:0]  out;
  logic              out_ready;
  logic              f_ack;

  modport master (
    output mode, data_in, in_valid, is_last, byte_num, f_ack,
    input  buffer_full, out, out_ready
  );

  modport slave (
    input  mode, data_in, in_valid, is_last, byte_num, f_ack,
    output buffer_full, out, out_ready
  );

endinterface

// File: rtl/sha3_pad_word.sv
// Combinational padding of one 64-bit word: domain byte after the data, 0x80 in the final rate slot.
module sha3_pad_word
  import sha3_padder_dilithium_pkg::*;
(
  input  logic [WORD_W-1:0] data_in,
  input  logic [2:0]        byte_num,
  input  logic              is_last,
  input  logic              is_final_slot,
  input  logic [7:0]        domain,
  output logic [WORD_W-1:0] padded_c
);

  always_comb begin
    padded_c = data_in;
    if (is_last) begin
      for (int b = 0; b < 8; b++) begin
        if (3'(b) == byte_num)
          padded_c[63-8*b -: 8] = domain;
        else if (3'(b) > byte_num)
          padded_c[63-8*b -: 8] = 8'h00;
      end
    end
    // Shares a byte with the domain byte when the message ends in byte 7 of the last slot.
    if (is_final_slot)
      padded_c[7:0] = padded_c[7:0] | END_BYTE;
  end

endmodule

// File: rtl/sha3_padder_dilithium.sv
// SHA3/SHAKE multi-rate padder for Dilithium: packs message words into rate blocks and pads.
// Optional build macro SHA3_PAD_BLOCK_CNT_EN adds an 8-bit count of consumed blocks.
module sha3_padder_dilithium
  import sha3_padder_dilithium_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  sha3_padder_dilithium_if.slave bus
`ifdef SHA3_PAD_BLOCK_CNT_EN
  , output logic [7:0]           block_cnt
`endif
);

  typedef enum logic [1:0] {S_FILL, S_PAD, S_FULL, S_DONE} state_t;

  state_t                             state;
  logic [CNT_W-1:0]                   cnt;
  logic [1:0]                         mode_r;
  logic                               started;
  logic                               pad_done;
  logic                               out_ready_r;
  logic                               buffer_full_r;
  logic [0:MAX_WORDS-1][WORD_W-1:0]   blk;

  logic [1:0]        cur_mode_c;
  logic              at_last_c;
  logic [WORD_W-1:0] pw_data_c;
  logic              pw_last_c;
  logic              pw_final_c;
  logic [7:0]        domain_c;
  logic [WORD_W-1:0] word_c;

  // Mode is locked by the first accepted word of the message.
  assign cur_mode_c = started ? mode_r : bus.mode;
  assign at_last_c  = (cnt == last_word_idx(cur_mode_c));
  assign domain_c   = domain_byte(cur_mode_c);
  assign pw_data_c  = (state == S_FILL) ? bus.data_in : '0;
  assign pw_last_c  = (state == S_FILL) && bus.is_last;
  assign pw_final_c = at_last_c && ((state == S_PAD) || pw_last_c);

  sha3_pad_word u_pad_word (
    .data_in       (pw_data_c),
    .byte_num      (bus.byte_num),
    .is_last       (pw_last_c),
    .is_final_slot (pw_final_c),
    .domain        (domain_c),
    .padded_c      (word_c)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_FILL;
      cnt           <= '0;
      mode_r        <= MODE_XOF;
      started       <= 1'b0;
      pad_done      <= 1'b0;
      out_ready_r   <= 1'b0;
      buffer_full_r <= 1'b0;
      blk           <= '0;
`ifdef SHA3_PAD_BLOCK_CNT_EN
      block_cnt     <= 8'd0;
`endif
    end else begin
      case (state)
        S_FILL: begin
          if (bus.in_valid) begin
            blk[cnt] <= word_c;
            if (!started) begin
              started <= 1'b1;
              mode_r  <= bus.mode;
            end
            if (at_last_c) begin
              state         <= S_FULL;
              out_ready_r   <= 1'b1;
              buffer_full_r <= 1'b1;
              pad_done      <= bus.is_last;
            end else begin
              cnt <= cnt + CNT_W'(1);
              if (bus.is_last) begin
                state         <= S_PAD;
                buffer_full_r <= 1'b1;
              end
            end
          end
        end
        S_PAD: begin
          blk[cnt] <= word_c;
          if (at_last_c) begin
            state       <= S_FULL;
            out_ready_r <= 1'b1;
            pad_done    <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_FULL: begin
          if (bus.f_ack) begin
            blk         <= '0;
            cnt         <= '0;
            out_ready_r <= 1'b0;
`ifdef SHA3_PAD_BLOCK_CNT_EN
            block_cnt   <= block_cnt + 8'd1;
`endif
            if (pad_done) begin
              state <= S_DONE;
            end else begin
              state         <= S_FILL;
              buffer_full_r <= 1'b0;
            end
          end
        end
        S_DONE: begin
          buffer_full_r <= 1'b1;
        end
        default: state <= S_FILL;
      endcase
    end
  end

  assign bus.out         = blk;
  assign bus.out_ready   = out_ready_r;
  assign bus.buffer_full = buffer_full_r;

endmodule

// File: tb/tb_sha3_padder_dilithium.sv
// Directed self-checking bench for sha3_padder_dilithium (define SHA3_PAD_BLOCK_CNT_EN to cover block_cnt).
module tb_sha3_padder_dilithium;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  int   lat;

  sha3_padder_dilithium_if bus ();

`ifdef SHA3_PAD_BLOCK_CNT_EN
  logic [7:0] block_cnt;
`endif

  sha3_padder_dilithium dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef SHA3_PAD_BLOCK_CNT_EN
    , .block_cnt (block_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] word_at(input int i);
    return bus.out[1343-64*i -: 64];
  endfunction

  function automatic logic [63:0] or_words(input int lo, input int hi);
    logic [63:0] acc = '0;
    for (int i = lo; i <= hi; i++) acc |= word_at(i);
    return acc;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic send(input logic [63:0] d, input logic last, input logic [2:0] bn, input logic [1:0] m);
    bus.data_in = d; bus.is_last = last; bus.byte_num = bn; bus.mode = m; bus.in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.in_valid = 1'b0; bus.is_last = 1'b0;
  endtask

  task automatic ack();
    bus.f_ack = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.f_ack = 1'b0;
  endtask

  // Extra edges after the accepting edge until out_ready, bounded.
  task automatic wait_ready(output int n);
    n = 0;
    while (!bus.out_ready && n < 100) begin
      @(posedge clk); @(negedge clk);
      n++;
    end
  endtask

  initial begin
    bus.mode = 2'd0; bus.data_in = '0; bus.in_valid = 1'b0; bus.is_last = 1'b0;
    bus.byte_num = 3'd0; bus.f_ack = 1'b0;
    @(negedge clk);
    do_reset();

    // Reset state
    check("rst_out_ready", 64'(bus.out_ready), 64'd0);
    check("rst_buffer_full", 64'(bus.buffer_full), 64'd0);
    check("rst_out_zero", 64'(|bus.out), 64'd0);

    // G mode, single short last word
    send(64'h0102030405060708, 1'b1, 3'd3, 2'd3);
    check("g_pad_busy", 64'(bus.buffer_full), 64'd1);
    wait_ready(lat);
    check("g_latency", 64'(lat + 1), 64'd9);
    check("g_word0", word_at(0), 64'h0102030600000000);
    check("g_words1_7", or_words(1, 7), 64'd0);
    check("g_word8", word_at(8), 64'h0000000000000080);
    check("g_below_rate", 64'(|bus.out[575:0]), 64'd0);
    ack();
    check("g_done_ready", 64'(bus.out_ready), 64'd0);
    check("g_done_full", 64'(bus.buffer_full), 64'd1);
    check("g_done_out", 64'(|bus.out), 64'd0);
    bus.data_in = 64'hFFFF_FFFF_FFFF_FFFF; bus.in_valid = 1'b1;
    repeat (3) begin @(posedge clk); @(negedge clk); end
    bus.in_valid = 1'b0;
    check("g_done_ignores_in", 64'(|bus.out | bus.out_ready), 64'd0);

    // XOF: exact-boundary message, stalled block, then a full padding block
    do_reset();
    for (int i = 0; i < 21; i++)
      send(64'hA5A5_0000_0000_0000 | 64'(i), 1'b0, 3'd0, 2'd0);
    check("xof_ready_now", 64'(bus.out_ready), 64'd1);
    check("xof_b1_w0", word_at(0), 64'hA5A5_0000_0000_0000);
    check("xof_b1_w10", word_at(10), 64'hA5A5_0000_0000_000A);
    check("xof_b1_w20", word_at(20), 64'hA5A5_0000_0000_0014);
    bus.data_in = 64'h1234_5678_9ABC_DEF0; bus.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); @(negedge clk);
      bus.data_in = bus.data_in + 64'd1;
    end
    bus.in_valid = 1'b0;
    check("stall_full", 64'(bus.buffer_full), 64'd1);
    check("stall_ready", 64'(bus.out_ready), 64'd1);
    check("stall_w0", word_at(0), 64'hA5A5_0000_0000_0000);
    check("stall_w20", word_at(20), 64'hA5A5_0000_0000_0014);
    ack();
    check("ack_out_zero", 64'(|bus.out), 64'd0);
    check("ack_full_low", 64'(bus.buffer_full), 64'd0);
    check("ack_ready_low", 64'(bus.out_ready), 64'd0);
    send(64'hDEAD_BEEF_DEAD_BEEF, 1'b1, 3'd0, 2'd3);
    wait_ready(lat);
    check("xof_b2_latency", 64'(lat + 1), 64'd21);
    check("xof_b2_w0", word_at(0), 64'h1F00_0000_0000_0000);
    check("xof_b2_mid", or_words(1, 19), 64'd0);
    check("xof_b2_w20", word_at(20), 64'h0000_0000_0000_0080);
    ack();

    // KDF: domain and end byte merge in the last slot
    do_reset();
    for (int i = 0; i < 16; i++)
      send(64'h0101_0101_0101_0101 * 64'(i + 1), 1'b0, 3'd0, 2'd1);
    send(64'h0102030405060708, 1'b1, 3'd7, 2'd1);
    check("kdf_ready_now", 64'(bus.out_ready), 64'd1);
    check("kdf_w0", word_at(0), 64'h0101_0101_0101_0101);
    check("kdf_w16", word_at(16), 64'h010203040506079F);
    check("kdf_below_rate", 64'(|bus.out[255:0]), 64'd0);
    ack();

    // G: merged 0x86 in the last slot
    do_reset();
    for (int i = 0; i < 8; i++)
      send(64'h0F0F_0F0F_0F0F_0F0F, 1'b0, 3'd0, 2'd3);
    send(64'hA1A2A3A4A5A6A7A8, 1'b1, 3'd7, 2'd3);
    check("g86_ready_now", 64'(bus.out_ready), 64'd1);
    check("g86_w8", word_at(8), 64'hA1A2A3A4A5A6A786);
    check("g86_below_rate", 64'(|bus.out[575:0]), 64'd0);
    ack();

    // H: reset while padding (with in_valid held), then a fresh message
    do_reset();
    send(64'hAABB_CCDD_EEFF_0011, 1'b1, 3'd2, 2'd2);
    repeat (3) begin @(posedge clk); @(negedge clk); end
    bus.data_in = 64'h7777_7777_7777_7777; bus.in_valid = 1'b1; bus.is_last = 1'b0;
    do_reset();
    bus.in_valid = 1'b0;
    check("rst_pad_out", 64'(|bus.out), 64'd0);
    check("rst_pad_ready", 64'(bus.out_ready), 64'd0);
    check("rst_pad_full", 64'(bus.buffer_full), 64'd0);
    for (int i = 0; i < 3; i++)
      send(64'hC0DE_0000_0000_0000 | 64'(i), 1'b0, 3'd0, 2'd2);
    bus.f_ack = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.f_ack = 1'b0;
    send(64'h1122334455667788, 1'b1, 3'd5, 2'd0);
    wait_ready(lat);
    check("h_latency", 64'(lat + 1), 64'd14);
    check("h_w0", word_at(0), 64'hC0DE_0000_0000_0000);
    check("h_w2", word_at(2), 64'hC0DE_0000_0000_0002);
    check("h_w3", word_at(3), 64'h11223344551F0000);
    check("h_w16", word_at(16), 64'h0000_0000_0000_0080);
    check("h_below_rate", 64'(|bus.out[255:0]), 64'd0);
    ack();

`ifdef SHA3_PAD_BLOCK_CNT_EN
    // Three-block XOF message
    do_reset();
    check("bc_reset", 64'(block_cnt), 64'd0);
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 21; i++)
        send(64'(i + 1), 1'b0, 3'd0, 2'd0);
      ack();
    end
    send(64'h55, 1'b1, 3'd1, 2'd0);
    wait_ready(lat);
    ack();
    check("bc_three", 64'(block_cnt), 64'd3);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
